msk_sb_pipe_ctrl: RTL and testbench

Elastic pipeline controller for the masked S-box datapath, whose stages are enabled share registers clocked on `clk`. It tracks which stages hold valid sharings, drives each stage's register enable, and provides valid/ready handshakes at input and output. Stages holding masked multiplications need a fresh randomness word on each capture, so the controller also handshakes with the PRNG. It sits between the Clyde round sequencer (upstream) and the L-box/tweakey logic (downstream). It never touches share data, only control.

---
 rtl/msk_sb_pipe_ctrl_pkg.sv | 14 +
 rtl/msk_sb_pipe_ctrl_if.sv | 43 ++++
 rtl/msk_sb_pipe_ctrl_stage_slot.sv | 36 +++
 rtl/msk_sb_pipe_ctrl.sv | 77 +++++++
 tb/tb_msk_sb_pipe_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/msk_sb_pipe_ctrl_pkg.sv
// Shared constants for the masked S-box pipeline controller.
// Optional feature macro: MSK_SB_RND_STALL_EN (randomness-valid stalls).
package msk_ctrl_pkg;

   // Upper bound on pipeline depth supported by the controller.
   localparam int MAX_STAGES = 8;

   // Default depth of the S-box share-register pipeline.
   localparam int DEF_STAGES = 3;

   // Default randomness map: stages 0 and 1 hold masked multiplications.
   localparam logic [MAX_STAGES-1:0] DEF_RND_MASK = 8'b0000_0011;

endpackage

// File: rtl/msk_sb_pipe_ctrl_if.sv
// Handshake bundle between the pipeline controller and its environment.
// master = environment (sequencer, PRNG, sink), slave = controller.
interface msk_sb_pipe_ctrl_if
   import msk_ctrl_pkg::*;
#(
   parameter int STAGES = DEF_STAGES
);

   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic              rnd_valid;
   logic              rnd_ready;
   logic [STAGES-1:0] en;
   logic              out_valid;
   logic              out_ready;
   logic              busy;

   modport master (
      output flush,
      output in_valid,
      output rnd_valid,
      output out_ready,
      input  in_ready,
      input  rnd_ready,
      input  en,
      input  out_valid,
      input  busy
   );

   modport slave (
      input  flush,
      input  in_valid,
      input  rnd_valid,
      input  out_ready,
      output in_ready,
      output rnd_ready,
      output en,
      output out_valid,
      output busy
   );

endinterface

// File: rtl/msk_sb_pipe_ctrl_stage_slot.sv
// One pipeline stage of the controller: occupancy bit plus the
// capture/free decision for its share register.
module msk_stage_slot
   import msk_ctrl_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic flush,
   input  logic src,    // upstream holds a valid sharing
   input  logic rok,    // randomness available (or not needed) for this stage
   input  logic leave,  // current occupant moves on this cycle
   output logic occ,
   output logic free,
   output logic cap
);

   logic kill;

   assign kill = rst | flush;

   // A stage can accept when empty or when its occupant departs this cycle.
   assign free = ~occ | leave;

   // Capture only when real data arrives; bubbles never re-clock the register.
   assign cap  = src & free & rok & ~kill;

   // Occupancy: set on capture, cleared when the occupant leaves; reset/flush empty it.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         occ <= 1'b0;
      end else begin
         occ <= cap | (occ & ~leave);
      end
   end

endmodule

// File: rtl/msk_sb_pipe_ctrl.sv
// Elastic control for the masked S-box share-register pipeline.
// Tracks stage occupancy, drives per-stage register enables and the
// in/out/PRNG handshakes. Never touches share data.
// Optional macro MSK_SB_RND_STALL_EN: when defined, masked stages wait for
// rnd_valid; when undefined, the PRNG is assumed to deliver every cycle.
module msk_sb_pipe_ctrl
   import msk_ctrl_pkg::*;
#(
   parameter int                STAGES   = DEF_STAGES,
   parameter logic [STAGES-1:0] RND_MASK = STAGES'(DEF_RND_MASK)
) (
   input  logic              clk,
   input  logic              rst,
   msk_sb_pipe_ctrl_if.slave bus
);

   logic              kill;
   logic              out_fire;
   logic [STAGES-1:0] occ;
   logic [STAGES-1:0] free;
   logic [STAGES-1:0] cap;
   logic [STAGES-1:0] rok;
   logic [STAGES-1:0] src;
   logic [STAGES-1:0] leave;
   logic              unused_free;

   assign kill     = rst | bus.flush;
   assign out_fire = occ[STAGES-1] & bus.out_ready;

`ifdef MSK_SB_RND_STALL_EN
   // Masked stages may only capture while a fresh randomness word is offered.
   assign rok = ~RND_MASK | {STAGES{bus.rnd_valid}};
`else
   // PRNG delivers every cycle, so randomness never gates a capture.
   logic unused_rnd_valid;
   assign rok              = '1;
   assign unused_rnd_valid = bus.rnd_valid;
`endif

   // Stage chain: data flows 0 -> STAGES-1, free flows back from the sink.
   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      if (i == 0) begin : g_src_in
         assign src[i] = bus.in_valid;
      end else begin : g_src_prev
         assign src[i] = occ[i-1];
      end

      if (i == STAGES - 1) begin : g_leave_out
         assign leave[i] = out_fire;
      end else begin : g_leave_next
         assign leave[i] = cap[i+1];
      end

      msk_stage_slot u_slot (
         .clk   (clk),
         .rst   (rst),
         .flush (bus.flush),
         .src   (src[i]),
         .rok   (rok[i]),
         .leave (leave[i]),
         .occ   (occ[i]),
         .free  (free[i]),
         .cap   (cap[i])
      );
   end

   // Only free[0] is needed outside the slots; the rest is consumed internally.
   assign unused_free = ^free;

   assign bus.en        = cap;
   assign bus.in_ready  = free[0] & rok[0] & ~kill;
   // One word serves every masked capture in the cycle; the datapath slices it.
   assign bus.rnd_ready = |(cap & RND_MASK);
   assign bus.out_valid = occ[STAGES-1] & ~rst;
   assign bus.busy      = (|occ) & ~rst;

endmodule

// File: tb/tb_msk_sb_pipe_ctrl.sv
// Bench for msk_sb_pipe_ctrl: directed scenarios plus random traffic, all
// checked every cycle against a token-level model of the pipeline.
module tb_msk_sb_pipe_ctrl;

   localparam int             S    = 3;
   localparam logic [S-1:0]   MASK = 3'b011;

   logic clk = 1'b0;
   logic rst;

   msk_sb_pipe_ctrl_if #(.STAGES(S)) bus ();

   msk_sb_pipe_ctrl #(.STAGES(S), .RND_MASK(MASK)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Model: each slot holds an item id, or -1 when empty.
   int slot [S];
   int next_id = 0;

   logic [S-1:0] x_en;
   logic         x_in_ready, x_rnd_ready, x_out_valid, x_busy, x_out_fire;

   // Observed values of the most recent cycle, plus per-scenario statistics.
   logic [S-1:0] last_en;
   logic         last_ir, last_rr, last_ov, last_busy;
   int cyc, first_ov, s_ov, s_rr, s_en, s_men, s_en01, s_en2;

   task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit rnd_ok(int i);
`ifdef MSK_SB_RND_STALL_EN
      return !MASK[i] || bus.rnd_valid;
`else
      return 1'b1;
`endif
   endfunction

   // Work out which items can move this cycle, from the sink back to the source.
   task automatic model_eval();
      bit kill;
      bit space;
      bit have;
      kill       = rst || bus.flush;
      x_in_ready = 1'b0;
      x_en       = '0;
      x_out_fire = !rst && (slot[S-1] >= 0) && bus.out_ready;
      space      = (slot[S-1] < 0) || bus.out_ready;
      for (int i = S - 1; i >= 0; i--) begin
         have    = (i == 0) ? bus.in_valid : (slot[i-1] >= 0);
         x_en[i] = have && space && rnd_ok(i) && !kill;
         if (i == 0) x_in_ready = space && rnd_ok(0) && !kill;
         else        space      = (slot[i-1] < 0) || x_en[i];
      end
      x_rnd_ready = |(x_en & MASK);
      x_out_valid = !rst && (slot[S-1] >= 0);
      x_busy      = 1'b0;
      for (int i = 0; i < S; i++) if (slot[i] >= 0) x_busy = !rst;
   endtask

   task automatic model_commit();
      if (rst || bus.flush) begin
         for (int i = 0; i < S; i++) slot[i] = -1;
      end else begin
         for (int i = S - 1; i >= 0; i--) begin
            if (x_en[i]) begin
               if (i == 0) begin
                  slot[0] = next_id;
                  next_id++;
               end else begin
                  slot[i] = slot[i-1];
               end
            end else if ((i == S - 1) ? x_out_fire : x_en[i+1]) begin
               slot[i] = -1;
            end
         end
      end
   endtask

   task automatic clear_stats();
      cyc = 0; first_ov = -1; s_ov = 0; s_rr = 0; s_en = 0; s_men = 0; s_en01 = 0; s_en2 = 0;
   endtask

   task automatic cycle(bit iv, bit rv, bit orr, bit fl, bit r);
      rst           = r;
      bus.in_valid  = iv;
      bus.rnd_valid = rv;
      bus.out_ready = orr;
      bus.flush     = fl;
      @(negedge clk);
      model_eval();
      last_en   = bus.en;
      last_ir   = bus.in_ready;
      last_rr   = bus.rnd_ready;
      last_ov   = bus.out_valid;
      last_busy = bus.busy;
      check_eq("en", 32'(last_en), 32'(x_en));
      check_eq("in_ready", 32'(last_ir), 32'(x_in_ready));
      check_eq("rnd_ready", 32'(last_rr), 32'(x_rnd_ready));
      check_eq("out_valid", 32'(last_ov), 32'(x_out_valid));
      check_eq("busy", 32'(last_busy), 32'(x_busy));
      if (last_ov && first_ov < 0) first_ov = cyc;
      s_ov   += int'(last_ov);
      s_rr   += int'(last_rr);
      s_en   += $countones(last_en);
      s_men  += $countones(last_en & MASK);
      s_en01 += $countones(last_en[1:0]);
      s_en2  += int'(last_en[2]);
      cyc++;
      @(posedge clk);
      model_commit();
      #1;
   endtask

   initial begin
      for (int i = 0; i < S; i++) slot[i] = -1;
      rst = 1'b1; bus.in_valid = 1'b0; bus.rnd_valid = 1'b0; bus.out_ready = 1'b0; bus.flush = 1'b0;

      // Reset: everything forced low even with in_valid asserted.
      cycle(1, 1, 1, 0, 1);
      cycle(1, 1, 1, 0, 1);
      check_eq("rst_en", 32'(last_en), 32'd0);
      check_eq("rst_in_ready", 32'(last_ir), 32'd0);

      // Streaming: 10 items at full rate.
      clear_stats();
      for (int k = 0; k < 16; k++) cycle(k < 10, 1, 1, 0, 0);
      check_eq("stream_first_ov", 32'(first_ov), 32'd3);
      check_eq("stream_n_out", 32'(s_ov), 32'd10);
      check_eq("stream_masked_caps", 32'(s_men), 32'd20);
      check_eq("stream_rnd_cycles", 32'(s_rr), 32'd11);

      // Backpressure: fill, hold, then release.
      for (int k = 0; k < 3; k++) cycle(1, 1, 0, 0, 0);
      cycle(1, 1, 0, 0, 0);
      check_eq("bp_in_ready", 32'(last_ir), 32'd0);
      check_eq("bp_en_hold", 32'(last_en), 32'd0);
      check_eq("bp_busy", 32'(last_busy), 32'd1);
      cycle(1, 1, 1, 0, 0);
      check_eq("bp_en_release", 32'(last_en), 32'b111);
      check_eq("bp_in_ready_release", 32'(last_ir), 32'd1);
      for (int k = 0; k < 4; k++) cycle(0, 1, 1, 0, 0);

      // Randomness starvation with two items in flight.
      cycle(1, 1, 1, 0, 0);
      cycle(1, 1, 1, 0, 0);
      clear_stats();
      for (int k = 0; k < 4; k++) cycle(1, 0, 1, 0, 0);
`ifdef MSK_SB_RND_STALL_EN
      check_eq("starve_en01", 32'(s_en01), 32'd0);
      check_eq("starve_en2", 32'(s_en2), 32'd1);
      check_eq("starve_rnd", 32'(s_rr), 32'd0);
`else
      check_eq("starve_en01", 32'(s_en01), 32'd8);
      check_eq("starve_en2", 32'(s_en2), 32'd4);
      check_eq("starve_rnd", 32'(s_rr), 32'd4);
`endif
      for (int k = 0; k < 5; k++) cycle(0, 1, 1, 0, 0);

      // Bubbles: alternate in_valid; enables only where data moves.
      clear_stats();
      for (int k = 0; k < 12; k++) cycle((k < 8) && (k % 2 == 0), 1, 1, 0, 0);
      check_eq("bubble_en_total", 32'(s_en), 32'd12);
      check_eq("bubble_n_out", 32'(s_ov), 32'd4);

      // Flush with three items in flight.
      for (int k = 0; k < 3; k++) cycle(1, 1, 0, 0, 0);
      cycle(1, 1, 1, 1, 0);
      check_eq("flush_en", 32'(last_en), 32'd0);
      check_eq("flush_in_ready", 32'(last_ir), 32'd0);
      check_eq("flush_rnd_ready", 32'(last_rr), 32'd0);
      clear_stats();
      cycle(0, 1, 1, 0, 0);
      check_eq("flush_busy_after", 32'(last_busy), 32'd0);
      for (int k = 0; k < 4; k++) cycle(0, 1, 1, 0, 0);
      check_eq("flush_no_out", 32'(s_ov), 32'd0);

      // Stream with the PRNG reporting nothing valid.
      clear_stats();
      for (int k = 0; k < 16; k++) cycle(k < 10, 0, 1, 0, 0);
`ifdef MSK_SB_RND_STALL_EN
      check_eq("nornd_n_out", 32'(s_ov), 32'd0);
`else
      check_eq("nornd_first_ov", 32'(first_ov), 32'd3);
      check_eq("nornd_n_out", 32'(s_ov), 32'd10);
`endif
      for (int k = 0; k < 4; k++) cycle(0, 1, 1, 0, 0);

      // Random traffic with occasional flush and reset.
      for (int k = 0; k < 500; k++) begin
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
               $urandom_range(0, 31) == 0, $urandom_range(0, 79) == 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
